// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus signals of the single-outstanding APB requester.
// The master modport is the requester's view; the slave modport is the controller/peripheral side.
interface apb_master_if #(
  parameter int datawidth    = 32,
  parameter int addresswidth = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [addresswidth-1:0] cmd_addr;
  logic [datawidth-1:0]    cmd_wdata;
  logic                    rsp_valid;
  logic [datawidth-1:0]    rsp_rdata;
  logic                    rsp_err;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [addresswidth-1:0] paddr;
  logic [datawidth-1:0]    pwdata;
  logic [datawidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns one command into an APB SETUP/ACCESS transfer,
// honouring pready wait states and pslverr, and aborting a stalled ACCESS after `timeout` cycles.
module apb_master #(
  parameter int datawidth    = 32,
  parameter int addresswidth = 8,
  parameter int timeout      = 16
) (
  input logic          clk,
  input logic          rst_n,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(timeout - 1);

  state_t                  state;
  logic [7:0]              wait_cnt;
  logic                    pwrite_q;
  logic [addresswidth-1:0] paddr_q;
  logic [datawidth-1:0]    pwdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [datawidth-1:0]    rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            state    <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready is tested first so a response on the timeout edge still completes normally
          if (bus.pready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pslverr;
            rsp_rdata_q <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
            state       <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.psel      = (state != IDLE);
  assign bus.penable   = (state == ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level schedule model checked every cycle, plus directed
// literal checks for the write, wait-state read, slave error, timeout, back-to-back and reset cases.
module tb_apb_master;

  localparam int T  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk;
  logic rst_n;

  apb_master_if #(.datawidth(DW), .addresswidth(AW)) bus ();

  apb_master #(.datawidth(DW), .addresswidth(AW), .timeout(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the in-flight transfer: acceptance cycle, response cycle and slave behaviour.
  int          cyc = 0;
  int          n_accepted = 0;
  bit          inflight = 1'b0;
  int          a_cyc = 0;
  int          c_cyc = 0;
  bit          x_write, x_pslverr, x_timeout;
  int          x_w;
  logic [31:0] x_prdata;
  logic [7:0]  m_paddr;
  logic [31:0] m_pwdata, m_rdata;
  logic        m_pwrite, m_err;
  bit          e_busy, e_psel, e_pen, e_rv;

  // Per-command slave behaviour requested by the driver.
  int          drv_w;
  logic [31:0] drv_prdata;
  bit          drv_pslverr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks every output each cycle, then advances the model.
  initial begin
    m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_rdata = '0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inflight = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_rdata = '0; m_err = 1'b0;
      end
      e_busy = inflight && (cyc < c_cyc);
      e_psel = inflight && (cyc >= a_cyc + 1) && (cyc < c_cyc);
      e_pen  = inflight && (cyc >= a_cyc + 2) && (cyc < c_cyc);
      e_rv   = inflight && (cyc == c_cyc);
      chk("cmd_ready", bus.cmd_ready, !e_busy);
      chk("psel",      bus.psel,      e_psel);
      chk("penable",   bus.penable,   e_pen);
      chk("pwrite",    bus.pwrite,    m_pwrite);
      chk("paddr",     bus.paddr,     m_paddr);
      chk("pwdata",    bus.pwdata,    m_pwdata);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("rsp_err",   bus.rsp_err,   m_err);
      chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      if (rst_n) begin
        if (inflight && cyc == c_cyc - 1) begin
          m_err   = x_timeout ? 1'b1 : x_pslverr;
          m_rdata = (x_timeout || x_write || x_pslverr) ? 32'h0 : x_prdata;
        end
        if (!e_busy && bus.cmd_valid) begin
          inflight  = 1'b1;
          a_cyc     = cyc;
          x_write   = bus.cmd_write;
          x_w       = drv_w;
          x_prdata  = drv_prdata;
          x_pslverr = drv_pslverr;
          x_timeout = (drv_w >= T);
          c_cyc     = cyc + 2 + (x_timeout ? T : drv_w + 1);
          m_pwrite  = bus.cmd_write;
          m_paddr   = bus.cmd_addr;
          m_pwdata  = bus.cmd_wdata;
          n_accepted++;
        end
      end
      cyc++;
    end
  end

  // Slave: pready low through the requested wait states, noise wherever it must be ignored.
  initial begin
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    forever begin
      next_cycle();
      if (inflight && !x_timeout && cyc == a_cyc + 2 + x_w) begin
        bus.pready  = 1'b1;
        bus.prdata  = x_prdata;
        bus.pslverr = x_pslverr;
      end else begin
        bus.pready  = (inflight && cyc >= a_cyc + 2 && cyc < c_cyc) ? 1'b0 : 1'($urandom);
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
      end
    end
  end

  task automatic send(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input int w, input logic [31:0] prd, input bit err, output int acc);
    int n0;
    n0 = n_accepted;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    drv_w = w; drv_prdata = prd; drv_pslverr = err;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (n_accepted != n0) break;
    end
    if (n_accepted == n0) expire("accept");
    acc = a_cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = $urandom;
  endtask

  // Waits for rsp_valid, counting penable cycles on the way.
  task automatic wait_rsp(output int c, output int pen_cycles);
    c = -1;
    pen_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid) begin
        c = cyc;
        break;
      end
      if (bus.penable) pen_cycles++;
      next_cycle();
    end
    if (c < 0) expire("rsp_valid");
  endtask

  task automatic random_cmds(input int n);
    int acc, c, pc;
    for (int i = 0; i < n; i++) begin
      send(1'($urandom), 8'($urandom), $urandom, $urandom_range(0, 6), $urandom,
           $urandom_range(0, 3) == 0, acc);
      if ($urandom_range(0, 2) == 0) wait_rsp(c, pc);
      else repeat ($urandom_range(0, 2)) next_cycle();
    end
  endtask

  initial begin
    int a, a2, c, pc, rv_seen;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    drv_w = 0; drv_prdata = '0; drv_pslverr = 1'b0;
    repeat (3) next_cycle();
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_psel",      bus.psel,      1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    rst_n = 1'b1;
    next_cycle();

    // Zero-wait write
    send(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, a);
    chk("wr_setup_psel",    bus.psel,    1'b1);
    chk("wr_setup_penable", bus.penable, 1'b0);
    chk("wr_setup_paddr",   bus.paddr,   8'h10);
    chk("wr_setup_pwdata",  bus.pwdata,  32'hDEADBEEF);
    next_cycle();
    chk("wr_access_penable", bus.penable, 1'b1);
    chk("wr_access_paddr",   bus.paddr,   8'h10);
    chk("wr_access_pwdata",  bus.pwdata,  32'hDEADBEEF);
    next_cycle();
    chk("wr_rsp_cycle", cyc - a, 3);
    chk("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk("wr_rsp_err",   bus.rsp_err,   1'b0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);

    // Read with three wait states
    send(1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, a);
    wait_rsp(c, pc);
    chk("rd_penable_cycles", pc, 4);
    chk("rd_latency",        c - a, 6);
    chk("rd_rsp_rdata",      bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err",        bus.rsp_err, 1'b0);

    // Slave error on read
    send(1'b0, 8'h20, 32'h0, 0, 32'h1234, 1'b1, a);
    wait_rsp(c, pc);
    chk("err_rsp_err",   bus.rsp_err,   1'b1);
    chk("err_rsp_rdata", bus.rsp_rdata, 32'h0);

    // Timeout
    send(1'b0, 8'h30, 32'h0, 50, 32'h5555, 1'b0, a);
    wait_rsp(c, pc);
    chk("to_penable_cycles", pc, T);
    chk("to_latency",        c - a, T + 2);
    chk("to_rsp_err",        bus.rsp_err, 1'b1);
    chk("to_psel",           bus.psel, 1'b0);
    chk("to_cmd_ready",      bus.cmd_ready, 1'b1);

    // pready on the same edge the timeout would fire
    send(1'b0, 8'h31, 32'h0, T - 1, 32'hCAFE0001, 1'b0, a);
    wait_rsp(c, pc);
    chk("race_rsp_err",   bus.rsp_err,   1'b0);
    chk("race_rsp_rdata", bus.rsp_rdata, 32'hCAFE0001);

    // Back-to-back writes
    next_cycle();
    send(1'b1, 8'h01, 32'hAA, 0, 32'h0, 1'b0, a);
    send(1'b1, 8'h02, 32'hBB, 0, 32'h0, 1'b0, a2);
    chk("b2b_spacing", a2 - a, 3);
    chk("b2b_paddr",   bus.paddr,  8'h02);
    chk("b2b_pwdata",  bus.pwdata, 32'hBB);
    wait_rsp(c, pc);

    random_cmds(60);
    wait_rsp(c, pc);
    next_cycle();

    // Reset during a wait state
    send(1'b1, 8'h55, 32'h12345678, 50, 32'h0, 1'b0, a);
    next_cycle();
    next_cycle();
    chk("pre_rst_penable", bus.penable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_psel",      bus.psel,      1'b0);
    chk("rst_penable",   bus.penable,   1'b0);
    chk("rst_pwrite",    bus.pwrite,    1'b0);
    chk("rst_paddr",     bus.paddr,     8'h00);
    chk("rst_pwdata",    bus.pwdata,    32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err",   bus.rsp_err,   1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    next_cycle();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (bus.rsp_valid) rv_seen++;
    end
    chk("post_rst_no_rsp", rv_seen, 0);

    random_cmds(15);
    wait_rsp(c, pc);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
